// File: rtl/dehaze_pkg.sv
// Shared definitions for the dehazer atmospheric-light datapath.
package dehaze_pkg;

  // Local atmospheric-light estimation modes.
  typedef enum logic [1:0] {
    MODE_BYPASS    = 2'd0,
    MODE_SCALE     = 2'd1,
    MODE_TILE_PEAK = 2'd2,
    MODE_BLEND     = 2'd3
  } mode_e;

  // Width of a counter that walks 0 .. n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ale_chan_calc.sv
// Combinational per-channel local atmospheric-light arithmetic.
module ale_chan_calc
  import dehaze_pkg::*;
#(
  parameter int W = 8
) (
  input  mode_e          mode,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   d,
  input  logic [W-1:0]   tmax,
  output logic [W-1:0]   res
);

  // Rounding constant for the SCALE product (one half in W-bit fixed point).
  localparam logic [2*W-1:0] HALF = (2*W)'(1) << (W-1);

  logic [2*W-1:0] prod;
  logic [2*W-1:0] prod_rnd;
  logic [W-1:0]   peak;
  logic [W:0]     sum;

  // Select the estimate for this channel; every path is a pure function of its inputs.
  always_comb begin
    prod     = (2*W)'(a) * (2*W)'(d);
    prod_rnd = prod + HALF;
    peak     = (a < tmax) ? a : tmax;
    sum      = {1'b0, a} + {1'b0, peak} + (W+1)'(1);
    res      = a;
    case (mode)
      MODE_BYPASS:    res = a;
      // (2^W-1)^2 + 2^(W-1) stays below 2^(2W), so the upper half never overflows.
      MODE_SCALE:     res = prod_rnd[2*W-1:W];
      MODE_TILE_PEAK: res = peak;
      MODE_BLEND:     res = sum[W:1];
      default:        res = a;
    endcase
  end

endmodule

// File: rtl/local_ale_stream.sv
// Streaming local atmospheric-light estimator: tile-latched globals and mode,
// tile running peak of the dark channel, two-stage valid/ready pipeline.
module local_ale_stream
  import dehaze_pkg::*;
#(
  parameter int W        = 8,
  parameter int NCH      = 3,
  parameter int TILE_LEN = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         mode,
  input  logic [NCH*W-1:0]   a_global,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       in_dark,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NCH*W-1:0]   out_a_local,
  output logic               out_tile_end,
  output logic [W-1:0]       out_tile_max
);

  localparam int CW = cnt_width(TILE_LEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(TILE_LEN - 1);

  // Tile tracking state
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [W-1:0]       tmax_q, tmax_d;
  mode_e              mode_lat_q;
  logic [NCH*W-1:0]   glob_lat_q;

  // Stage 1 registers
  logic               s1_valid_q;
  logic [W-1:0]       s1_dark_q;
  logic [W-1:0]       s1_tmax_q;
  mode_e              s1_mode_q;
  logic [NCH*W-1:0]   s1_glob_q;
  logic               s1_end_q;

  // Stage 2 (output) registers
  logic               out_valid_q;
  logic [NCH*W-1:0]   out_a_local_q;
  logic               out_tile_end_q;
  logic [W-1:0]       out_tile_max_q;

  logic               en;
  logic               accept;
  logic               first_px;
  logic               tile_end;
  mode_e              mode_eff;
  logic [NCH*W-1:0]   glob_eff;
  logic [NCH*W-1:0]   chan_res;

  // The whole pipeline moves together whenever the output slot is free or draining.
  assign en       = out_ready || !out_valid_q;
  assign in_ready = en && !rst;
  assign accept   = in_valid && in_ready;

  // Per-pixel tile bookkeeping; the first pixel of a tile uses the live mode/globals.
  always_comb begin
    first_px = (cnt_q == '0);
    tile_end = (cnt_q == CNT_LAST) || in_last;
    cnt_d    = tile_end ? '0 : cnt_q + CW'(1);
    tmax_d   = (first_px || in_dark > tmax_q) ? in_dark : tmax_q;
    mode_eff = first_px ? mode_e'(mode) : mode_lat_q;
    glob_eff = first_px ? a_global : glob_lat_q;
  end

  // Tile counter, running peak and tile-latched controls advance only on accepted pixels.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      tmax_q     <= '0;
      mode_lat_q <= MODE_BYPASS;
      glob_lat_q <= '0;
    end else if (accept) begin
      cnt_q  <= cnt_d;
      tmax_q <= tmax_d;
      if (first_px) begin
        mode_lat_q <= mode_e'(mode);
        glob_lat_q <= a_global;
      end
    end
  end

  // Stage 1: capture the pixel with its effective tile context.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_dark_q  <= '0;
      s1_tmax_q  <= '0;
      s1_mode_q  <= MODE_BYPASS;
      s1_glob_q  <= '0;
      s1_end_q   <= 1'b0;
    end else if (en) begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_dark_q <= in_dark;
        s1_tmax_q <= tmax_d;
        s1_mode_q <= mode_eff;
        s1_glob_q <= glob_eff;
        s1_end_q  <= tile_end;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_chan
      ale_chan_calc #(.W(W)) u_calc (
        .mode (s1_mode_q),
        .a    (s1_glob_q[gi*W +: W]),
        .d    (s1_dark_q),
        .tmax (s1_tmax_q),
        .res  (chan_res[gi*W +: W])
      );
    end
  endgenerate

  // Stage 2: register the per-channel results; held while downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q    <= 1'b0;
      out_a_local_q  <= '0;
      out_tile_end_q <= 1'b0;
      out_tile_max_q <= '0;
    end else if (en) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_a_local_q  <= chan_res;
        out_tile_end_q <= s1_end_q;
        out_tile_max_q <= s1_tmax_q;
      end
    end
  end

  assign out_valid    = out_valid_q;
  assign out_a_local  = out_a_local_q;
  assign out_tile_end = out_tile_end_q;
  assign out_tile_max = out_tile_max_q;

endmodule
